// File: rtl/full_adder_pkg.sv
// ============================================================================
// Module : full_adder_pkg
// Brief  : Shared constants, vector typedefs and the 1-bit full-adder
//          equation used by the ripple-carry full_adder datapath cell.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package full_adder_pkg;

  // Classic single-bit full adder when the top is left at its default.
  localparam int unsigned DEFAULT_WIDTH = 1;

  // Sum and carry-chain vectors at the default width.  The carry vector is
  // one bit wider than the sum: c[0] is the carry in, c[WIDTH] the carry out.
  typedef logic [DEFAULT_WIDTH-1:0] sum_vec_t;
  typedef logic [DEFAULT_WIDTH:0]   carry_vec_t;

  // Result of one 1-bit cell.
  typedef struct packed {
    logic s;
    logic co;
  } fa_result_t;

  // Single-bit full adder.  The carry uses the propagate form
  // (a&b | ci&(a^b)) so the XOR is shared with the sum.
  function automatic fa_result_t fa_bit(input logic a, input logic b, input logic ci);
    fa_result_t r;
    logic       p;
    p    = a ^ b;
    r.s  = p ^ ci;
    r.co = (a & b) | (ci & p);
    return r;
  endfunction

endpackage : full_adder_pkg

`default_nettype wire

// File: rtl/full_adder_fa_cell.sv
// ============================================================================
// Module : fa_cell
// Brief  : Purely combinational 1-bit full adder, one link of the ripple
//          carry chain inside full_adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fa_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  fa_result_t w_res;

  // Evaluate the shared full-adder equation for this bit position.
  always_comb begin
    w_res = fa_bit(a, b, ci);
  end

  assign s  = w_res.s;
  assign co = w_res.co;

endmodule : fa_cell

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// Module : full_adder
// Brief  : Registered WIDTH-bit ripple-carry adder, {Cout,S} = A + B + Cin,
//          one result per cycle with one cycle of latency and no
//          backpressure.  Outputs hold their value while in_valid is low.
// Config : define FULL_ADDER_OVF_EN to add the registered signed-overflow
//          output V (carry into MSB xor carry out of MSB).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             V
`endif
);

  // Carry chain: w_carry[0] is the carry in, w_carry[WIDTH] the carry out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  assign w_carry[0] = Cin;

  // One fa_cell per bit, carry rippling from LSB to MSB.
  generate
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      fa_cell u_cell (
        .a  (A[i]),
        .b  (B[i]),
        .ci (w_carry[i]),
        .s  (w_sum[i]),
        .co (w_carry[i+1])
      );
    end
  endgenerate

  // Result register: reset clears, accepted vectors load, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end
  end

  assign S         = r_sum;
  assign Cout      = r_cout;
  assign out_valid = r_out_valid;

`ifdef FULL_ADDER_OVF_EN
  logic r_v;

  // Signed overflow is loaded together with the sum so they stay coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= 1'b0;
    end else if (in_valid) begin
      r_v <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
    end
  end

  assign V = r_v;
`endif

endmodule : full_adder

`default_nettype wire

// File: tb/tb_full_adder.sv
// ============================================================================
// Module : tb_full_adder
// Brief  : Self-checking bench for full_adder at WIDTH=1 and WIDTH=8 against
//          an arithmetic reference model, plus literal directed vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       a1, b1, cin1;
  logic [7:0] a8, b8;
  logic       cin8;

  logic       s1, cout1, ov1;
  logic [7:0] s8;
  logic       cout8, ov8;
`ifdef FULL_ADDER_OVF_EN
  logic       v1, v8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (a1),
    .B         (b1),
    .Cin       (cin1),
    .S         (s1),
    .Cout      (cout1),
    .out_valid (ov1)
`ifdef FULL_ADDER_OVF_EN
    ,
    .V         (v1)
`endif
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (a8),
    .B         (b8),
    .Cin       (cin8),
    .S         (s8),
    .Cout      (cout8),
    .out_valid (ov8)
`ifdef FULL_ADDER_OVF_EN
    ,
    .V         (v8)
`endif
  );

  // ---------------- reference model (plain arithmetic) ----------------
  logic       m_ready = 1'b0;
  logic       m_ov;
  logic       m1_s, m1_c, m1_v;
  logic [7:0] m8_s;
  logic       m8_c, m8_v;
  int         t1, t8;

  always @(posedge clk) begin
    t1 = int'(a1) + int'(b1) + int'(cin1);
    t8 = int'(a8) + int'(b8) + int'(cin8);
    if (rst) begin
      m_ready <= 1'b1;
      m_ov    <= 1'b0;
      m1_s <= 1'b0; m1_c <= 1'b0; m1_v <= 1'b0;
      m8_s <= 8'h00; m8_c <= 1'b0; m8_v <= 1'b0;
    end else begin
      m_ov <= in_valid;
      if (in_valid) begin
        m1_s <= t1[0];
        m1_c <= t1[1];
        // signed overflow: operands share a sign and the sum's sign differs
        m1_v <= (a1 == b1) && (t1[0] != a1);
        m8_s <= t8[7:0];
        m8_c <= t8[8];
        m8_v <= (a8[7] == b8[7]) && (t8[7] != a8[7]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("model ov1",   {31'd0, ov1},   {31'd0, m_ov});
      chk("model s1",    {31'd0, s1},    {31'd0, m1_s});
      chk("model cout1", {31'd0, cout1}, {31'd0, m1_c});
      chk("model ov8",   {31'd0, ov8},   {31'd0, m_ov});
      chk("model s8",    {24'd0, s8},    {24'd0, m8_s});
      chk("model cout8", {31'd0, cout8}, {31'd0, m8_c});
`ifdef FULL_ADDER_OVF_EN
      chk("model v1",    {31'd0, v1},    {31'd0, m1_v});
      chk("model v8",    {31'd0, v8},    {31'd0, m8_v});
`endif
    end
  end

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] pat [8];
  logic [1:0] exp_sc [8];

  initial begin
    pat    = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    exp_sc = '{2'b00,  2'b10,  2'b10,  2'b01,  2'b10,  2'b01,  2'b01,  2'b11};

    // Reset held for two cycles with a live vector on the inputs.
    rst = 1'b1; in_valid = 1'b1;
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    step(); step();
    chk("reset s1",   {31'd0, s1},    32'd0);
    chk("reset cout1",{31'd0, cout1}, 32'd0);
    chk("reset ov1",  {31'd0, ov1},   32'd0);
    chk("reset s8",   {24'd0, s8},    32'd0);
    chk("reset ov8",  {31'd0, ov8},   32'd0);
    rst = 1'b0;

    // Exhaustive 1-bit truth table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = pat[i];
      step();
      chk($sformatf("tt %03b {S,Cout}", pat[i]), {30'd0, s1, cout1}, {30'd0, exp_sc[i]});
      chk("tt ov1", {31'd0, ov1}, 32'd1);
    end

    // Hold: outputs persist when in_valid drops.
    {a1, b1, cin1} = 3'b111;
    step();
    in_valid = 1'b0; {a1, b1, cin1} = 3'b000; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    step();
    chk("hold s1",    {31'd0, s1},    32'd1);
    chk("hold cout1", {31'd0, cout1}, 32'd1);
    chk("hold ov1",   {31'd0, ov1},   32'd0);

    // 8-bit boundaries.
    in_valid = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    step();
    chk("w8 ff+01 s",    {24'd0, s8},    32'h00);
    chk("w8 ff+01 cout", {31'd0, cout8}, 32'd1);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    step();
    chk("w8 7f+01 s",    {24'd0, s8},    32'h80);
    chk("w8 7f+01 cout", {31'd0, cout8}, 32'd0);
`ifdef FULL_ADDER_OVF_EN
    chk("w8 7f+01 v",    {31'd0, v8},    32'd1);
`endif
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    step();
    chk("w8 ones s",    {24'd0, s8},    32'hFF);
    chk("w8 ones cout", {31'd0, cout8}, 32'd1);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    step();
    chk("w8 zero s",    {24'd0, s8},    32'h00);
    chk("w8 zero cout", {31'd0, cout8}, 32'd0);

    // Mid-stream reset discards the in-flight vector.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1;
    step();
    chk("pre-rst s8", {24'd0, s8}, 32'h47);
    a8 = 8'hA0; b8 = 8'h0B; rst = 1'b1;
    step();
    chk("mid-rst s8",  {24'd0, s8},  32'd0);
    chk("mid-rst ov8", {31'd0, ov8}, 32'd0);
    rst = 1'b0; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    step();
    chk("post-rst s8",    {24'd0, s8},    32'h00);
    chk("post-rst cout8", {31'd0, cout8}, 32'd1);
    chk("post-rst ov8",   {31'd0, ov8},   32'd1);

    // Randomized traffic, checked by the model every cycle.
    for (int n = 0; n < 1000; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 63) == 0);
      a8   = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      a1   = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_full_adder

`default_nettype wire
